// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, variable-latency memory between the pipeline's
// instruction-fetch port (IF) and data port (MEM). One access is in flight at
// a time. The data port wins any tie. Each completed result is held until the
// pipeline consumes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_take   fetch request, address, consume strobe
//   if_rdata/if_stall        held instruction, fetch-not-satisfied
//   d_ren/d_wen/d_addr/      data read/write request, address, write data,
//   d_wdata/d_take           consume strobe
//   d_rdata/d_stall          held read data, data-not-satisfied
//   m_req/m_we/m_addr/       memory request (level), write enable, address,
//   m_wdata                  write data; stable for the whole access
//   m_rdata/m_ack            memory read data, one-cycle completion pulse
//   bus_err                  sticky timeout flag (cleared by rst only)
//   dbg_state                current FSM state (0 idle, 1 data, 2 fetch)
//
// Handshake: a port's request is "satisfied" when its stall output is low,
// which happens only while a held result matches the presented request. The
// pipeline consumes that result by raising take in a cycle where stall is low;
// the hold is released on the following edge. The memory side is a level
// request: m_req stays high with stable m_we/m_addr/m_wdata until the cycle
// in which m_ack is sampled high (or the access times out).
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255   // legal range 1..65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_take,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_take,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_stall,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ack,
    output logic                  bus_err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_D_BUSY = 2'd1,
        S_I_BUSY = 2'd2
    } state_t;

    // Busy-cycle count at which the access is abandoned.
    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_m_req;
    logic                  r_m_we;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_bus_err;

    logic                  r_if_hold;
    logic [ADDR_WIDTH-1:0] r_if_haddr;
    logic                  r_d_hold;
    logic [ADDR_WIDTH-1:0] r_d_haddr;
    logic                  r_d_hwe;
    logic [15:0]           r_cnt;

    logic                  w_if_pend;
    logic                  w_d_pend;
    logic                  w_launch_d;
    logic                  w_launch_i;
    logic                  w_finish;
    logic                  w_abort;

    // A request is satisfied only by a held result for the very same access;
    // a changed fetch address (branch redirect) or a changed data address or
    // direction makes the request pending again.
    assign w_if_pend = if_req & ~(r_if_hold & (r_if_haddr == if_addr));
    assign w_d_pend  = (d_ren | d_wen)
                     & ~(r_d_hold & (r_d_haddr == d_addr) & (r_d_hwe == d_wen));

    assign if_stall  = w_if_pend;
    assign d_stall   = w_d_pend;

    assign m_req     = r_m_req;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign bus_err   = r_bus_err;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_launch_d   = 1'b0;
        w_launch_i   = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // m_ack seen here is stale (after reset or timeout) and ignored.
                if (w_d_pend) begin
                    w_launch_d   = 1'b1;
                    w_next_state = S_D_BUSY;
                end else if (w_if_pend) begin
                    w_launch_i   = 1'b1;
                    w_next_state = S_I_BUSY;
                end
            end
            S_D_BUSY, S_I_BUSY: begin
                // An ack in the last allowed cycle still completes normally.
                if (m_ack) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_finish     = 1'b1;
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_bus_err  <= 1'b0;
            r_if_hold  <= 1'b0;
            r_if_haddr <= '0;
            r_d_hold   <= 1'b0;
            r_d_haddr  <= '0;
            r_d_hwe    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // Consume first; a capture later in this block overrides it.
            if (if_take && r_if_hold && !w_if_pend) begin
                r_if_hold <= 1'b0;
            end
            if (d_take && r_d_hold && !w_d_pend) begin
                r_d_hold <= 1'b0;
            end

            if (w_launch_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= d_wen;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
            end else if (w_launch_i) begin
                r_m_req   <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= if_addr;
            end

            if (w_finish) begin
                r_m_req <= 1'b0;
                r_m_we  <= 1'b0;
                // An aborted access still produces a (all-ones) result so the
                // waiting pipeline stage can move on.
                if (r_state == S_D_BUSY) begin
                    r_d_hold  <= 1'b1;
                    r_d_haddr <= r_m_addr;
                    r_d_hwe   <= r_m_we;
                    if (w_abort) begin
                        r_d_rdata <= '1;
                    end else if (!r_m_we) begin
                        r_d_rdata <= m_rdata;
                    end
                end else begin
                    r_if_hold  <= 1'b1;
                    r_if_haddr <= r_m_addr;
                    r_if_rdata <= w_abort ? '1 : m_rdata;
                end
            end

            if (w_abort) begin
                r_bus_err <= 1'b1;
            end

            if ((r_state == S_IDLE) || w_finish) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule
